pwm_update_sequencer: RTL and testbench
=======================================

Name: pwm_update_sequencer

Overview:
- Controls the PWM datapath behind the AXI4-Lite register file. Owns the carrier counter and NUM_CH duty compares.
- Accepts per-channel duty and period writes into staging registers. On commit, transfers staging to active registers at the next period boundary, so the waveform never glitches mid-period.
- Sits between the AXI4-Lite register decode (the requester) and the PWM output pins.

Parameters:
- NUM_CH, 4, number of PWM channels.
- CNT_W, 16, width of the counter, period and duty values.
- PERIOD_RST, 999, active and staged period after reset.

Ports:
- ACLK  in  1  system clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- enable  in  1  run the carrier counter; when low the counter is held at 0 and pwm_out is 0.
- cfg_wr_valid  in  1  duty write request.
- cfg_wr_ready  out  1  duty write accepted when valid & ready.
- cfg_wr_ch  in  $clog2(NUM_CH)  target channel.
- cfg_wr_duty  in  CNT_W  staged duty value.
- cfg_period_wr  in  1  single-cycle strobe: write cfg_period to staging.
- cfg_period  in  CNT_W  staged period (counter max).
- commit  in  1  single-cycle pulse: request staging-to-active transfer.
- commit_pending  out  1  high while a commit is armed and waiting for the boundary.
- update_done  out  1  single-cycle pulse in the cycle the new values take effect.
- period_start  out  1  single-cycle pulse when the counter is 0 and enable is high.
- cnt  out  CNT_W  current carrier count.
- pwm_out  out  NUM_CH  PWM outputs.

Behaviour:
- Reset:
  - cnt=0; pwm_out=0; commit_pending=0; update_done=0; period_start=0; cfg_wr_ready=1.
  - Staged and active period = PERIOD_RST; all staged and active duties = 0.
  - Reset asserted mid-commit discards the armed commit and all staging.
- Counter, with enable=1:
  - cnt increments by 1 per cycle.
  - When cnt == period_act, the next value is 0 (the wrap).
  - period_act = 0 gives cnt stuck at 0, with a wrap every cycle.
  - With enable=0: cnt=0, no wraps.
- Output: pwm_out[i] is registered: pwm_out[i] <= enable & (cnt_next < duty_act[i]).
  - duty = 0 gives a constant 0.
  - duty > period_act gives a constant 1.
  - Comparison is unsigned, full CNT_W width.
- Staging writes:
  - A duty handshake writes duty_stg[cfg_wr_ch]; cfg_wr_ch >= NUM_CH is accepted and dropped.
  - cfg_period_wr writes period_stg; it is ignored while ARMED.
- FSM states:
  - IDLE: cfg_wr_ready=1. commit moves the FSM to ARMED at the next edge. A write handshake in the same cycle as commit is included in the commit.
  - ARMED: commit_pending=1, cfg_wr_ready=0 (writes stall and staging is frozen). Further commits are ignored (no queueing).
    - If enable=1 and cnt == period_act, go to LOAD.
    - If enable=0, go to LOAD at the next edge.
  - LOAD (1 cycle): active <= staging; update_done=1; cnt=0; return to IDLE.
- Commit timing:
  - Latency with enable=1 is 1 cycle to arm, then until the wrap, plus 1 cycle.
  - The first period after LOAD uses the new period_act and duties.
- period_start is high in every cycle with enable=1 and cnt==0, including the cycle after LOAD.
- Disabling while ARMED: the armed commit completes via the enable=0 path.

Decomposition:
- Shared package pwm_pkg holds:
  - CNT_W default;
  - the FSM state enum {IDLE, ARMED, LOAD};
  - the duty array typedef.
- One sub-module: pwm_compare_ch (per-channel registered comparator), instantiated NUM_CH times via a generate loop. The FSM and counter stay in the top module.

Test Plan:
- Reset, enable=1, no writes: cnt counts 0..999 and wraps; pwm_out = 4'b0000; period_start pulses every 1000 cycles.
- Write duties 250/500/750/0 for ch0..3, period=999, commit at cnt=10:
  - commit_pending stays high until cnt=999;
  - update_done fires with cnt=0;
  - ch0..3 then stay high for 250/500/750/0 cycles per period.
- Second commit while ARMED, plus a cfg_wr_valid attempt:
  - cfg_wr_ready stays 0 and the write is not accepted;
  - the second commit has no effect;
  - only one update_done pulse occurs.
- Duty 1000 with period 999: pwm_out constant 1. Period 0 with duty 1: pwm_out constant 1 and period_start high every cycle.
- Commit with enable=0: update_done two cycles after commit. Assert ARESET while ARMED: next cycle commit_pending=0 and period_act=999.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the PWM update sequencer: counter width default, FSM states, duty array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int NUM_CH_DEF = 4;

   // Commit sequencing: IDLE accepts writes, ARMED waits for the boundary, LOAD copies staging.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      LOAD  = 2'd2
   } state_t;

   typedef logic [CNT_W_DEF-1:0] duty_t;
   typedef duty_t duty_arr_t [NUM_CH_DEF];

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: registered compare of the next carrier count against the active duty.
// Latency: 1 cycle (output lines up with the count it was computed from).
// Backpressure: none, free-running every cycle.
module pwm_compare_ch #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] cnt_next_i,
   input  logic [CNT_W-1:0] duty_i,
   output logic             pwm_o
);

   logic pwm_q;
   logic pwm_d;

   // High while the upcoming count sits below the duty; disabled forces low.
   always_comb begin
      pwm_d = enable_i & (cnt_next_i < duty_i);
   end

   // Output register, cleared on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_update_sequencer.sv
// PWM carrier counter plus NUM_CH duty compares with staged, boundary-aligned updates.
// Latency: commit arms next edge; load happens the cycle after the wrap (next edge when disabled).
// Backpressure: cfg_wr_ready low from arm until load completes; period strobes ignored while armed.
module pwm_update_sequencer
   import pwm_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int PERIOD_RST = 999
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      enable,
   input  logic                      cfg_wr_valid,
   output logic                      cfg_wr_ready,
   input  logic [$clog2(NUM_CH)-1:0] cfg_wr_ch,
   input  logic [CNT_W-1:0]          cfg_wr_duty,
   input  logic                      cfg_period_wr,
   input  logic [CNT_W-1:0]          cfg_period,
   input  logic                      commit,
   output logic                      commit_pending,
   output logic                      update_done,
   output logic                      period_start,
   output logic [CNT_W-1:0]          cnt,
   output logic [NUM_CH-1:0]         pwm_out
);

   state_t state_q, state_d;

   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [CNT_W-1:0]             period_act_q, period_act_d;
   logic [CNT_W-1:0]             period_stg_q, period_stg_d;
   logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
   logic [NUM_CH-1:0][CNT_W-1:0] duty_stg_q, duty_stg_d;

   logic at_wrap;
   logic wr_hs;

   assign at_wrap = (cnt_q == period_act_q);
   assign wr_hs   = cfg_wr_valid & cfg_wr_ready;

   // FSM state register; reset drops any armed commit.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: arm on commit, load at the wrap or immediately when disabled.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (commit) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (!enable || at_wrap) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: writes only accepted while idle, status flags per state.
   always_comb begin
      cfg_wr_ready   = 1'b0;
      commit_pending = 1'b0;
      update_done    = 1'b0;
      unique case (state_q)
         IDLE:    cfg_wr_ready   = 1'b1;
         ARMED:   commit_pending = 1'b1;
         LOAD:    update_done    = 1'b1;
         default: cfg_wr_ready   = 1'b0;
      endcase
   end

   // Carrier next count: held at 0 when disabled or loading, wraps after period_act.
   always_comb begin
      if (state_q == LOAD || !enable || at_wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Staging and active next values; LOAD copies the staging captured before this cycle.
   always_comb begin
      duty_stg_d   = duty_stg_q;
      period_stg_d = period_stg_q;
      duty_act_d   = duty_act_q;
      period_act_d = period_act_q;
      if (wr_hs && (int'(cfg_wr_ch) < NUM_CH)) begin
         duty_stg_d[cfg_wr_ch] = cfg_wr_duty;
      end
      if (cfg_period_wr && (state_q != ARMED)) begin
         period_stg_d = cfg_period;
      end
      if (state_q == LOAD) begin
         duty_act_d   = duty_stg_q;
         period_act_d = period_stg_q;
      end
   end

   // Datapath registers: counter, staged and active period/duties.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt_q        <= '0;
         period_act_q <= CNT_W'(PERIOD_RST);
         period_stg_q <= CNT_W'(PERIOD_RST);
         duty_act_q   <= '0;
         duty_stg_q   <= '0;
      end else begin
         cnt_q        <= cnt_d;
         period_act_q <= period_act_d;
         period_stg_q <= period_stg_d;
         duty_act_q   <= duty_act_d;
         duty_stg_q   <= duty_stg_d;
      end
   end

   assign cnt          = cnt_q;
   assign period_start = enable & (cnt_q == '0);

   // Compares see the duty that will be active next cycle so the first post-load period uses new duties.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_compare_ch #(
         .CNT_W (CNT_W)
      ) u_cmp (
         .clk_i      (ACLK),
         .rst_i      (ARESET),
         .enable_i   (enable),
         .cnt_next_i (cnt_d),
         .duty_i     (duty_act_d[i]),
         .pwm_o      (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Bench for pwm_update_sequencer: directed scenarios plus randomized traffic against a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_update_sequencer;
   import pwm_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_wr_valid = 1'b0;
   logic        cfg_wr_ready;
   logic [1:0]  cfg_wr_ch = '0;
   logic [15:0] cfg_wr_duty = '0;
   logic        cfg_period_wr = 1'b0;
   logic [15:0] cfg_period = '0;
   logic        commit = 1'b0;
   logic        commit_pending;
   logic        update_done;
   logic        period_start;
   logic [15:0] cnt;
   logic [3:0]  pwm_out;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 ACLK = ~ACLK;

   pwm_update_sequencer #(
      .NUM_CH     (4),
      .CNT_W      (16),
      .PERIOD_RST (999)
   ) dut (
      .ACLK           (ACLK),
      .ARESET         (ARESET),
      .enable         (enable),
      .cfg_wr_valid   (cfg_wr_valid),
      .cfg_wr_ready   (cfg_wr_ready),
      .cfg_wr_ch      (cfg_wr_ch),
      .cfg_wr_duty    (cfg_wr_duty),
      .cfg_period_wr  (cfg_period_wr),
      .cfg_period     (cfg_period),
      .commit         (commit),
      .commit_pending (commit_pending),
      .update_done    (update_done),
      .period_start   (period_start),
      .cnt            (cnt),
      .pwm_out        (pwm_out)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // State after the most recent edge; the negedge compares it, then advances it
   // with the inputs that the coming edge will sample.
   logic [15:0] m_cnt, m_pact, m_pstg, nc, np;
   duty_arr_t   m_dact, m_dstg, nda;
   bit          m_armed, m_load;
   logic [3:0]  m_pwm;

   always @(negedge ACLK) begin
      if (chk_en) begin
         chk("m_cnt",     cnt,            m_cnt);
         chk("m_pwm",     pwm_out,        m_pwm);
         chk("m_pending", commit_pending, m_armed);
         chk("m_done",    update_done,    m_load);
         chk("m_ready",   cfg_wr_ready,   !(m_armed || m_load));
         chk("m_pstart",  period_start,   enable && (m_cnt == 16'd0));
      end
      if (ARESET) begin
         m_cnt = 0; m_pact = 999; m_pstg = 999;
         for (int i = 0; i < 4; i++) begin m_dact[i] = 0; m_dstg[i] = 0; end
         m_armed = 0; m_load = 0; m_pwm = 0;
      end else begin
         if (m_load || !enable || m_cnt == m_pact) nc = 0;
         else nc = m_cnt + 16'd1;
         nda = m_dact; np = m_pact;
         if (m_load) begin nda = m_dstg; np = m_pstg; end
         if (cfg_wr_valid && !m_armed && !m_load && int'(cfg_wr_ch) < 4)
            m_dstg[cfg_wr_ch] = cfg_wr_duty;
         if (cfg_period_wr && !m_armed) m_pstg = cfg_period;
         if (m_load) m_load = 0;
         else if (m_armed) begin
            if (!enable || m_cnt == m_pact) begin m_armed = 0; m_load = 1; end
         end else if (commit) m_armed = 1;
         for (int i = 0; i < 4; i++) m_pwm[i] = enable && (nc < nda[i]);
         m_cnt = nc; m_dact = nda; m_pact = np;
      end
   end

   task automatic wait_done(input string nm, input int budget);
      int n;
      n = 0;
      while (!update_done && n < budget) begin step(); n++; end
      chk(nm, update_done, 1);
   endtask

   task automatic write_duty(input int ch, input int d);
      cfg_wr_valid = 1; cfg_wr_ch = 2'(ch); cfg_wr_duty = 16'(d);
      step();
      cfg_wr_valid = 0;
   endtask

   initial begin
      int n, ps_cnt, pwm_seen, dones, prev_cnt, prev_pend, maxc;
      int hi [4];
      int dv [4];
      bit ok0, ok1, ok2, ok3;

      dv[0] = 250; dv[1] = 500; dv[2] = 750; dv[3] = 0;
      step(); step();
      chk_en = 1;
      ARESET = 0;
      // reset state with enable low
      chk("rst_cnt", cnt, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_pending", commit_pending, 0);
      chk("rst_done", update_done, 0);
      chk("rst_ready", cfg_wr_ready, 1);
      chk("rst_pstart", period_start, 0);

      // free run at reset period: wraps after 999
      step();
      enable = 1;
      ps_cnt = 0; pwm_seen = 0;
      for (int i = 1; i <= 2000; i++) begin
         step();
         if (i == 999)  chk("run_cnt999", cnt, 999);
         if (i == 1000) chk("run_wrap0", cnt, 0);
         ps_cnt += int'(period_start);
         pwm_seen += int'(pwm_out != 0);
      end
      chk("run_pstart_pulses", ps_cnt, 2);
      chk("run_pwm_zero", pwm_seen, 0);

      // duties 250/500/750/0, commit at cnt 10, second commit and a write while armed
      for (int i = 0; i < 4; i++) write_duty(i, dv[i]);
      cfg_period_wr = 1; cfg_period = 999; step(); cfg_period_wr = 0;
      n = 0;
      while (cnt != 10 && n < 2000) begin step(); n++; end
      chk("at_cnt10", cnt, 10);
      commit = 1; step(); commit = 0;
      chk("armed", commit_pending, 1);
      chk("armed_stall", cfg_wr_ready, 0);
      commit = 1; cfg_wr_valid = 1; cfg_wr_ch = 0; cfg_wr_duty = 5;
      step();
      commit = 0; cfg_wr_valid = 0;
      chk("still_armed", commit_pending, 1);
      n = 0; prev_cnt = 0; prev_pend = 0;
      while (!update_done && n < 1100) begin
         prev_cnt = int'(cnt); prev_pend = int'(commit_pending); step(); n++;
      end
      chk("done1", update_done, 1);
      chk("done1_cnt", cnt, 0);
      chk("pend_till_999", prev_cnt, 999);
      chk("pend_before_load", prev_pend, 1);
      step();
      chk("post_load_cnt", cnt, 0);
      chk("post_load_pstart", period_start, 1);
      for (int c = 0; c < 4; c++) hi[c] = 0;
      dones = 0;
      for (int k = 0; k < 1000; k++) begin
         for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
         dones += int'(update_done);
         step();
      end
      for (int c = 0; c < 4; c++) chk($sformatf("high_ch%0d", c), hi[c], dv[c]);
      chk("single_done", dones, 0);

      // duty above period: constant high
      write_duty(0, 1000);
      commit = 1; step(); commit = 0;
      wait_done("done_duty1000", 1100);
      step();
      ok0 = 1;
      for (int k = 0; k < 1000; k++) begin ok0 &= pwm_out[0]; step(); end
      chk("duty1000_const1", ok0, 1);

      // period 0 with duty 1: counter stuck at 0, pulse every cycle
      cfg_period_wr = 1; cfg_period = 0;
      cfg_wr_valid = 1; cfg_wr_ch = 1; cfg_wr_duty = 1;
      step();
      cfg_period_wr = 0; cfg_wr_valid = 0;
      commit = 1; step(); commit = 0;
      wait_done("done_per0", 1100);
      step();
      ok1 = 1; ok2 = 1; ok3 = 1;
      for (int k = 0; k < 20; k++) begin
         ok1 &= period_start; ok2 &= pwm_out[1]; ok3 &= (cnt == 0);
         step();
      end
      chk("per0_pstart", ok1, 1);
      chk("per0_pwm1", ok2, 1);
      chk("per0_cnt", ok3, 1);

      // commit while disabled: done two cycles after the commit cycle
      enable = 0; step();
      commit = 1; step(); commit = 0;
      chk("dis_done_early", update_done, 0);
      chk("dis_pending", commit_pending, 1);
      step();
      chk("dis_done", update_done, 1);
      step();
      chk("dis_ready_back", cfg_wr_ready, 1);

      // reset while armed discards the commit and restores period 999
      ARESET = 1; step(); ARESET = 0; enable = 1;
      n = 0;
      while (cnt != 5 && n < 100) begin step(); n++; end
      commit = 1; step(); commit = 0;
      chk("rst_arm_pending", commit_pending, 1);
      ARESET = 1; step(); ARESET = 0;
      chk("rst_arm_cleared", commit_pending, 0);
      chk("rst_arm_ready", cfg_wr_ready, 1);
      dones = 0; maxc = 0;
      for (int k = 0; k < 1100; k++) begin
         step();
         dones += int'(update_done);
         if (int'(cnt) > maxc) maxc = int'(cnt);
      end
      chk("rst_arm_no_done", dones, 0);
      chk("rst_arm_max_cnt", maxc, 999);

      // randomized traffic checked cycle by cycle against the model
      for (int k = 0; k < 6000; k++) begin
         enable        = ($urandom_range(0, 9) != 0);
         cfg_wr_valid  = ($urandom_range(0, 2) == 0);
         cfg_wr_ch     = 2'($urandom_range(0, 3));
         cfg_wr_duty   = 16'($urandom_range(0, 45));
         cfg_period_wr = ($urandom_range(0, 9) == 0);
         cfg_period    = 16'($urandom_range(0, 40));
         commit        = ($urandom_range(0, 19) == 0);
         ARESET        = ($urandom_range(0, 299) == 0);
         step();
      end
      ARESET = 0; commit = 0; cfg_wr_valid = 0; cfg_period_wr = 0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
